scene_render: RTL and testbench

//  Pixel compositor directly downstream of the game-logic block. Snapshots bird, pipe, coin, score and status

---
 rtl/scene_pkg.sv | 58 +++++
 rtl/scene_render_if.sv | 31 +++
 rtl/score_bcd.sv | 57 +++++
 rtl/scene_render.sv | 168 ++++++++++++++++
 tb/tb_scene_render.sv | 200 ++++++++++++++++++++
 5 files changed

// File: rtl/scene_pkg.sv
// Shared constants, colour palette and 3x5 digit glyph ROM for the scene compositor.
package scene_pkg;

   typedef logic [11:0] rgb_t;

   typedef enum logic [1:0] {
      ST_PLAY   = 2'b00,
      ST_START1 = 2'b01,
      ST_START2 = 2'b10
   } status_e;

   localparam logic [10:0] BIRD_X   = 11'd40;
   localparam logic [10:0] BIRD_W   = 11'd16;
   localparam logic [10:0] PIPE_W   = 11'd50;
   localparam logic [10:0] CAP_H    = 11'd8;
   localparam logic [10:0] CAP_OUT  = 11'd4;
   localparam logic [10:0] COIN_W   = 11'd16;
   localparam logic [10:0] GROUND_Y = 11'd16;

   localparam rgb_t C_BIRD_UP = 12'hFF0;
   localparam rgb_t C_BIRD_DN = 12'hF80;
   localparam rgb_t C_COIN    = 12'hFD0;
   localparam rgb_t C_PIPE    = 12'h0A0;
   localparam rgb_t C_CAP     = 12'h0F0;
   localparam rgb_t C_GROUND  = 12'h840;
   localparam rgb_t C_SKY     = 12'h6CF;
   localparam rgb_t C_TINT    = 12'h348;
   localparam rgb_t C_DIGIT   = 12'hFFF;

   // Row 0 is the top of the glyph; bit 2 of the returned row is the leftmost column.
   function automatic logic [2:0] glyphRow(input logic [3:0] digit, input logic [2:0] row);
      logic [14:0] g;
      logic [2:0]  bits;
      case (digit)
         4'd0:    g = 15'b111_101_101_101_111;
         4'd1:    g = 15'b010_110_010_010_111;
         4'd2:    g = 15'b111_001_111_100_111;
         4'd3:    g = 15'b111_001_111_001_111;
         4'd4:    g = 15'b101_101_111_001_001;
         4'd5:    g = 15'b111_100_111_001_111;
         4'd6:    g = 15'b111_100_111_101_111;
         4'd7:    g = 15'b111_001_001_001_001;
         4'd8:    g = 15'b111_101_111_101_111;
         4'd9:    g = 15'b111_101_111_001_111;
         default: g = 15'b0;
      endcase
      case (row)
         3'd0:    bits = g[14:12];
         3'd1:    bits = g[11:9];
         3'd2:    bits = g[8:6];
         3'd3:    bits = g[5:3];
         3'd4:    bits = g[2:0];
         default: bits = 3'b000;
      endcase
      return bits;
   endfunction

endpackage

// File: rtl/scene_render_if.sv
// Pixel-timing, game-state and video-output bundle between game logic, scene_render and the VGA driver.
interface scene_render_if;
   import scene_pkg::*;

   logic        i_pixEn;
   logic        i_frameStart;
   logic [9:0]  i_pixX;
   logic [9:0]  i_pixY;
   logic        i_videoOn;
   logic [1:0]  i_status;
   logic [15:0] i_score;
   logic [15:0] i_birdY;
   logic [31:0] i_pipe1;
   logic [31:0] i_pipe2;
   logic [31:0] i_pipe3;
   logic [31:0] i_coin;
   rgb_t        o_rgb;
   logic        o_snapDone;

   modport slave (
      input  i_pixEn, i_frameStart, i_pixX, i_pixY, i_videoOn, i_status, i_score,
             i_birdY, i_pipe1, i_pipe2, i_pipe3, i_coin,
      output o_rgb, o_snapDone
   );

   modport master (
      output i_pixEn, i_frameStart, i_pixX, i_pixY, i_videoOn, i_status, i_score,
             i_birdY, i_pipe1, i_pipe2, i_pipe3, i_coin,
      input  o_rgb, o_snapDone
   );
endinterface

// File: rtl/score_bcd.sv
// Iterative double-dabble: 16-bit binary to 5 BCD digits, done pulses 17 clocks after start.
module score_bcd (
   input  logic        clk,
   input  logic        rst,
   input  logic        i_start,
   input  logic [15:0] i_bin,
   output logic [19:0] o_bcd,
   output logic        o_done
);
   logic [15:0] r_bin;
   logic [19:0] r_acc;
   logic [4:0]  r_cnt;
   logic        r_busy;
   logic        r_done;
   logic [19:0] w_adj;
   logic        w_unusedMsb;

   always_comb begin
      w_adj = r_acc;
      for (int i = 0; i < 5; i++) begin
         if (r_acc[i*4 +: 4] >= 4'd5) w_adj[i*4 +: 4] = r_acc[i*4 +: 4] + 4'd3;
      end
   end

   assign w_unusedMsb = w_adj[19];

   // A start while busy simply reloads, restarting the conversion.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_bin  <= '0;
         r_acc  <= '0;
         r_cnt  <= '0;
         r_busy <= 1'b0;
         r_done <= 1'b0;
      end else begin
         r_done <= 1'b0;
         if (i_start) begin
            r_bin  <= i_bin;
            r_acc  <= '0;
            r_cnt  <= '0;
            r_busy <= 1'b1;
         end else if (r_busy) begin
            if (r_cnt == 5'd16) begin
               r_busy <= 1'b0;
               r_done <= 1'b1;
            end else begin
               r_acc <= {w_adj[18:0], r_bin[15]};
               r_bin <= {r_bin[14:0], 1'b0};
               r_cnt <= r_cnt + 5'd1;
            end
         end
      end
   end

   assign o_bcd  = r_acc;
   assign o_done = r_done;
endmodule

// File: rtl/scene_render.sv
// Frame-snapshot pixel compositor, 2-strobe pipeline to 12-bit RGB.
// Optional score overlay enabled by defining SCORE_OVERLAY_EN.
module scene_render
   import scene_pkg::*;
(
   input  logic           clk,
   input  logic           rst,
   scene_render_if.slave  bus
);
   logic [1:0]  r_status;
   logic [15:0] r_score;
   logic [15:0] r_birdY;
   logic [31:0] r_pipe [3];
   logic [31:0] r_coin;
   logic        r_frameOk;
   logic        r_snapDone;

   logic r_hitBird, r_hitCoin, r_hitPipe, r_hitCap, r_hitGround, r_hitDigit;
   logic r_vid1, r_rising1, r_tint1;
   rgb_t r_rgb;

   logic [10:0] w_x, w_gy, w_by, w_cx, w_cy;
   logic        w_hitBird, w_hitCoin, w_hitGround, w_hitDigit;
   logic [1:0]  w_pipeHits;
   rgb_t        w_color;
   logic        w_unused;

   // Returns {cap, body}; caps sit in the gap, against each edge, overhanging the body.
   function automatic logic [1:0] pipeHit(input logic [10:0] x, input logic [10:0] gy,
                                          input logic [27:0] p);
      logic [10:0] px, py, pe;
      logic        body, cap;
      px   = {1'b0, p[19:10]};
      py   = {1'b0, p[9:0]};
      pe   = py + {3'b000, p[27:20]};
      body = (x >= px) && (x < px + PIPE_W) && ((gy < py) || (gy >= pe));
      cap  = (x + CAP_OUT >= px) && (x < px + PIPE_W + CAP_OUT) &&
             (((gy >= py) && (gy < py + CAP_H)) || ((gy + CAP_H >= pe) && (gy < pe)));
      return {cap, body};
   endfunction

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_status   <= '0;
         r_score    <= '0;
         r_birdY    <= '0;
         for (int i = 0; i < 3; i++) r_pipe[i] <= '0;
         r_coin     <= '0;
         r_frameOk  <= 1'b0;
         r_snapDone <= 1'b0;
      end else begin
         r_snapDone <= bus.i_frameStart;
         if (bus.i_frameStart) begin
            r_status  <= bus.i_status;
            r_score   <= bus.i_score;
            r_birdY   <= bus.i_birdY;
            r_pipe[0] <= bus.i_pipe1;
            r_pipe[1] <= bus.i_pipe2;
            r_pipe[2] <= bus.i_pipe3;
            r_coin    <= bus.i_coin;
            r_frameOk <= 1'b1;
         end
      end
   end

   assign w_x  = {1'b0, bus.i_pixX};
   assign w_gy = 11'd479 - {1'b0, bus.i_pixY};
   assign w_by = {1'b0, r_birdY[9:0]};
   assign w_cx = {1'b0, r_coin[9:0]};
   assign w_cy = {1'b0, r_coin[19:10]};

   assign w_hitBird   = (w_x >= BIRD_X) && (w_x < BIRD_X + BIRD_W) &&
                        (w_gy >= w_by) && (w_gy < w_by + BIRD_W);
   assign w_hitCoin   = r_coin[31] && (w_x >= w_cx) && (w_x < w_cx + COIN_W) &&
                        (w_gy >= w_cy) && (w_gy < w_cy + COIN_W);
   assign w_hitGround = (w_gy < GROUND_Y);
   assign w_pipeHits  = pipeHit(w_x, w_gy, r_pipe[0][27:0]) |
                        pipeHit(w_x, w_gy, r_pipe[1][27:0]) |
                        pipeHit(w_x, w_gy, r_pipe[2][27:0]);

`ifdef SCORE_OVERLAY_EN
   logic [19:0] w_bcd, r_digits;
   logic        w_bcdDone;
   logic [10:0] w_dx, w_dy;
   logic [3:0]  w_nib;
   logic [2:0]  w_glyph;
   logic        w_unusedDig;

   score_bcd u_bcd (
      .clk     (clk),
      .rst     (rst),
      .i_start (r_snapDone),
      .i_bin   (r_score),
      .o_bcd   (w_bcd),
      .o_done  (w_bcdDone)
   );

   // Old digits stay on screen while a conversion is in flight.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)            r_digits <= '0;
      else if (w_bcdDone) r_digits <= w_bcd;
   end

   assign w_dx        = w_x - 11'd8;
   assign w_dy        = {1'b0, bus.i_pixY} - 11'd8;
   assign w_unusedDig = ^{w_dx[10:7], w_dx[1:0], w_dy[10:5], w_dy[1:0]};

   always_comb begin
      case (w_dx[6:4])
         3'd0:    w_nib = r_digits[19:16];
         3'd1:    w_nib = r_digits[15:12];
         3'd2:    w_nib = r_digits[11:8];
         3'd3:    w_nib = r_digits[7:4];
         3'd4:    w_nib = r_digits[3:0];
         default: w_nib = 4'd0;
      endcase
      w_glyph    = glyphRow(w_nib, w_dy[4:2]);
      w_hitDigit = 1'b0;
      if ((w_x >= 11'd8) && (w_x < 11'd88) && (bus.i_pixY >= 10'd8) && (bus.i_pixY < 10'd28)) begin
         case (w_dx[3:2])
            2'd0:    w_hitDigit = w_glyph[2];
            2'd1:    w_hitDigit = w_glyph[1];
            2'd2:    w_hitDigit = w_glyph[0];
            default: w_hitDigit = 1'b0;
         endcase
      end
   end

   assign w_unused = ^{r_birdY[14:10], r_pipe[0][31:28], r_pipe[1][31:28],
                       r_pipe[2][31:28], r_coin[30:20], w_unusedDig};
`else
   assign w_hitDigit = 1'b0;
   assign w_unused   = ^{r_score, r_birdY[14:10], r_pipe[0][31:28], r_pipe[1][31:28],
                         r_pipe[2][31:28], r_coin[30:20]};
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         {r_hitBird, r_hitCoin, r_hitPipe, r_hitCap, r_hitGround, r_hitDigit} <= '0;
         {r_vid1, r_rising1, r_tint1} <= '0;
         r_rgb <= '0;
      end else if (bus.i_pixEn) begin
         r_hitBird   <= w_hitBird;
         r_hitCoin   <= w_hitCoin;
         r_hitPipe   <= w_pipeHits[0];
         r_hitCap    <= w_pipeHits[1];
         r_hitGround <= w_hitGround;
         r_hitDigit  <= w_hitDigit;
         r_vid1      <= bus.i_videoOn;
         r_rising1   <= r_birdY[15];
         r_tint1     <= (r_status != ST_PLAY);
         r_rgb       <= (r_vid1 && r_frameOk) ? w_color : '0;
      end
   end

   always_comb begin
      w_color = r_tint1 ? C_TINT : C_SKY;
      if (r_hitDigit)       w_color = C_DIGIT;
      else if (r_hitBird)   w_color = r_rising1 ? C_BIRD_UP : C_BIRD_DN;
      else if (r_hitCoin)   w_color = C_COIN;
      else if (r_hitCap)    w_color = C_CAP;
      else if (r_hitPipe)   w_color = C_PIPE;
      else if (r_hitGround) w_color = C_GROUND;
   end

   assign bus.o_rgb      = r_rgb;
   assign bus.o_snapDone = r_snapDone;
endmodule

// File: tb/tb_scene_render.sv
// Directed self-checking bench for scene_render; overlay expectations follow SCORE_OVERLAY_EN.
module tb_scene_render;
   logic clk = 1'b0;
   logic rst;
   int   checks = 0;
   int   errors = 0;

   localparam logic [11:0] BLACK  = 12'h000;
   localparam logic [11:0] SKY    = 12'h6CF;
   localparam logic [11:0] TINT   = 12'h348;
   localparam logic [11:0] BUP    = 12'hFF0;
   localparam logic [11:0] BDN    = 12'hF80;
   localparam logic [11:0] COIN   = 12'hFD0;
   localparam logic [11:0] PIPE   = 12'h0A0;
   localparam logic [11:0] CAP    = 12'h0F0;
   localparam logic [11:0] GROUND = 12'h840;
`ifdef SCORE_OVERLAY_EN
   localparam logic [11:0] DIG_ON = 12'hFFF;
`else
   localparam logic [11:0] DIG_ON = 12'h6CF;
`endif

   scene_render_if bus();

   scene_render dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] mkPipe(input int gap, input int x, input int y);
      return {4'h0, gap[7:0], x[9:0], y[9:0]};
   endfunction

   function automatic logic [31:0] mkCoin(input logic vis, input int y, input int x);
      return {vis, 11'd0, y[9:0], x[9:0]};
   endfunction

   task automatic checkOutput(input string tag, input logic [11:0] actual, input logic [11:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
      end
   endtask

   task automatic strobe();
      @(negedge clk) bus.i_pixEn = 1'b1;
      @(negedge clk) bus.i_pixEn = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   task automatic applyStimulus(input int x, input int y, input logic vid);
      bus.i_pixX    = x[9:0];
      bus.i_pixY    = y[9:0];
      bus.i_videoOn = vid;
      strobe();
      strobe();
   endtask

   task automatic expectPixel(input string tag, input int x, input int y, input logic [11:0] exp);
      applyStimulus(x, y, 1'b1);
      checkOutput(tag, bus.o_rgb, exp);
   endtask

   task automatic snapshot();
      @(negedge clk) bus.i_frameStart = 1'b1;
      @(negedge clk) bus.i_frameStart = 1'b0;
      checkOutput("snap_done", {11'd0, bus.o_snapDone}, 12'd1);
      @(negedge clk);
      checkOutput("snap_done_low", {11'd0, bus.o_snapDone}, 12'd0);
      repeat (24) @(negedge clk);
   endtask

   initial begin
      rst              = 1'b1;
      bus.i_pixEn      = 1'b0;
      bus.i_frameStart = 1'b0;
      bus.i_pixX       = '0;
      bus.i_pixY       = '0;
      bus.i_videoOn    = 1'b0;
      bus.i_status     = 2'b00;
      bus.i_score      = 16'd0;
      bus.i_birdY      = 16'd400;
      bus.i_pipe1      = mkPipe(0, 1000, 0);
      bus.i_pipe2      = mkPipe(0, 1000, 0);
      bus.i_pipe3      = mkPipe(0, 1000, 0);
      bus.i_coin       = mkCoin(1'b0, 0, 1000);
      repeat (3) @(negedge clk);
      checkOutput("reset_rgb", bus.o_rgb, BLACK);
      checkOutput("reset_snap", {11'd0, bus.o_snapDone}, 12'd0);
      rst = 1'b0;

      expectPixel("pre_snap_black", 300, 100, BLACK);
      snapshot();
      expectPixel("sky", 300, 100, SKY);

      bus.i_birdY = 16'h8000 | 16'd240;
      snapshot();
      expectPixel("bird_up_tl", 40, 224, BUP);
      expectPixel("bird_up_br", 55, 239, BUP);
      expectPixel("bird_right_out", 56, 230, SKY);
      expectPixel("bird_below_out", 40, 240, SKY);
      bus.i_birdY = 16'd240;
      snapshot();
      expectPixel("bird_down", 47, 230, BDN);

      bus.i_birdY = 16'h8000 | 16'd10;
      snapshot();
      expectPixel("bird_over_ground", 45, 467, BUP);
      expectPixel("ground", 60, 467, GROUND);

      bus.i_birdY = 16'd400;
      bus.i_pipe1 = mkPipe(100, 200, 150);
      snapshot();
      expectPixel("pipe_body", 220, 400, PIPE);
      expectPixel("pipe_gap", 220, 270, SKY);
      expectPixel("cap_low_left", 196, 322, CAP);
      expectPixel("cap_low_right", 253, 329, CAP);
      expectPixel("cap_right_out", 254, 325, SKY);
      expectPixel("body_below_cap", 220, 330, PIPE);
      expectPixel("cap_high", 220, 230, CAP);
      expectPixel("body_above_cap", 220, 229, PIPE);
      expectPixel("gap_above_cap", 220, 238, SKY);

      bus.i_pipe1 = mkPipe(100, 400, 150);
      bus.i_birdY = 16'h8000 | 16'd240;
      expectPixel("hold_pipe", 220, 400, PIPE);
      expectPixel("hold_bird", 40, 224, SKY);
      snapshot();
      expectPixel("new_pipe_old_x", 220, 400, SKY);
      expectPixel("new_pipe_new_x", 420, 400, PIPE);
      expectPixel("new_bird", 40, 224, BUP);

      bus.i_birdY = 16'd400;
      bus.i_pipe1 = mkPipe(100, 620, 150);
      bus.i_coin  = mkCoin(1'b0, 70, 625);
      snapshot();
      expectPixel("edge_pipe_639", 639, 400, PIPE);
      expectPixel("edge_pipe_620", 620, 400, PIPE);
      expectPixel("no_wrap_0", 0, 400, SKY);
      expectPixel("no_wrap_29", 29, 400, SKY);
      expectPixel("edge_cap", 616, 322, CAP);
      expectPixel("coin_hidden", 630, 400, PIPE);
      bus.i_coin = mkCoin(1'b1, 70, 625);
      snapshot();
      expectPixel("coin_shown", 630, 400, COIN);

      bus.i_status = 2'b01;
      snapshot();
      expectPixel("tint_1p", 300, 100, TINT);
      expectPixel("tint_ground", 300, 470, GROUND);
      bus.i_status = 2'b10;
      snapshot();
      expectPixel("tint_2p", 300, 100, TINT);
      bus.i_status = 2'b00;
      snapshot();
      applyStimulus(300, 470, 1'b0);
      checkOutput("video_off", bus.o_rgb, BLACK);

      bus.i_score = 16'd12345;
      snapshot();
      expectPixel("d1_on", 12, 8, DIG_ON);
      expectPixel("d1_off", 8, 8, SKY);
      expectPixel("d1_gap", 20, 8, SKY);
      expectPixel("d2_on", 32, 12, DIG_ON);
      expectPixel("d2_off", 24, 12, SKY);
      expectPixel("d3_on", 43, 27, DIG_ON);
      expectPixel("d4_on", 56, 8, DIG_ON);
      expectPixel("d4_off", 60, 8, SKY);
      expectPixel("d5_on", 72, 12, DIG_ON);
      expectPixel("d5_off", 80, 12, SKY);
      bus.i_score = 16'd65535;
      snapshot();
      expectPixel("m6_on", 8, 12, DIG_ON);
      expectPixel("m6_off", 16, 12, SKY);
      expectPixel("m5_on", 32, 20, DIG_ON);
      expectPixel("m5_off", 24, 20, SKY);
      expectPixel("m3_on", 64, 12, DIG_ON);

      bus.i_pixX    = 10'd300;
      bus.i_pixY    = 10'd100;
      bus.i_videoOn = 1'b1;
      strobe();
      @(negedge clk) rst = 1'b1;
      #1;
      checkOutput("midframe_reset_rgb", bus.o_rgb, BLACK);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      checkOutput("midframe_reset_snap", {11'd0, bus.o_snapDone}, 12'd0);
      expectPixel("post_reset_black", 300, 100, BLACK);
      snapshot();
      expectPixel("post_reset_sky", 300, 100, SKY);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
